// File: rtl/hub_norm_shifter.sv
// hub_norm_shifter: post-LZA normalization for the HUB floating-point adder.
// Takes the effective-subtraction magnitude, the LZA left-shift prediction and
// the pre-normalization exponent. It produces a mantissa with its leading one in
// the MSB, fixes a one-bit LZA misprediction in either direction, adjusts the
// exponent and flushes zero/underflow results. Two register stages are joined by
// a valid/ready handshake that has no skid buffer.
module hub_norm_shifter #(
    parameter int M           = 23,
    parameter int E           = 8,
    parameter int SHIFT_WIDTH = $clog2(M + 2),
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [M+1:0]           in_mant,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    input  logic [E-1:0]           in_exp,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [M+1:0]           out_mant,
    output logic [E-1:0]           out_exp,
    output logic                   out_zero,
    output logic                   out_underflow,
    output logic                   out_corrected,
    output logic [CNT_WIDTH-1:0]   corr_count,
    input  logic                   corr_clear
);

    localparam int W  = M + 2;
    // One extra bit holds a shift amount of W, or one more than the largest prediction.
    localparam int AW = SHIFT_WIDTH + 1;
    localparam logic [AW-1:0]       W_SH  = AW'(W);
    localparam logic signed [E:0]   ONE_S = 1;

    // Saturating increment of the correction counter.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Handshake
    logic adv1, adv2;
    logic vld_p1_q, vld_p2_q;

    // Stage 1 registers
    logic [W-1:0]  mant_p1_q, mant_p1_d;
    logic [AW-1:0] amt_p1_q,  amt_p1_d;
    logic [E-1:0]  exp_p1_q,  exp_p1_d;
    logic          fix_p1_q,  fix_p1_d;
    logic          zero_p1_q, zero_p1_d;

    // Stage 1 helpers
    logic          zero_p0;
    logic          lost_p0;
    logic [AW-1:0] rsh_p0;
    logic [W-1:0]  hi_p0;

    // Stage 2 (output) registers
    logic [W-1:0]   out_mant_q, out_mant_d;
    logic [E-1:0]   out_exp_q,  out_exp_d;
    logic           out_zero_q, out_zero_d;
    logic           out_uf_q,   out_uf_d;
    logic           out_corr_q, out_corr_d;
    logic [CNT_WIDTH-1:0] cnt_q;

    // Stage 2 helpers
    logic                need_p1;
    logic [W-1:0]        mant2_p1;
    logic [AW-1:0]       amt2_p1;
    logic signed [E:0]   diff_p1;

    assign adv2     = !vld_p2_q || out_ready;
    assign adv1     = !vld_p1_q || adv2;
    assign in_ready = adv1;

    // ---- stage 0 -> 1: coarse shift; back off by one if the prediction overshoots
    always_comb begin
        zero_p0   = (in_mant == '0);
        // Bits that would pass above bit W-1 are the top in_shift bits of in_mant.
        rsh_p0    = W_SH - {1'b0, in_shift};
        hi_p0     = in_mant >> rsh_p0;
        lost_p0   = !zero_p0 && (({1'b0, in_shift} >= W_SH) || (hi_p0 != '0));
        mant_p1_d = in_mant << in_shift;
        amt_p1_d  = {1'b0, in_shift};
        fix_p1_d  = 1'b0;
        if (lost_p0) begin
            mant_p1_d = in_mant << (in_shift - 1'b1);
            amt_p1_d  = {1'b0, in_shift - 1'b1};
            fix_p1_d  = 1'b1;
        end
        zero_p1_d = zero_p0;
        exp_p1_d  = in_exp;
    end

    // Stage 1 valid, the only part of stage 1 that reset touches.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else if (adv1) begin
            vld_p1_q <= in_valid;
        end
    end

    // Stage 1 data capture.
    always_ff @(posedge clk) begin
        if (adv1) begin
            mant_p1_q <= mant_p1_d;
            amt_p1_q  <= amt_p1_d;
            exp_p1_q  <= exp_p1_d;
            fix_p1_q  <= fix_p1_d;
            zero_p1_q <= zero_p1_d;
        end
    end

    // ---- stage 1 -> 2: fine correction, exponent adjust and zero/underflow flush
    always_comb begin
        need_p1  = !zero_p1_q && !mant_p1_q[W-1];
        mant2_p1 = need_p1 ? (mant_p1_q << 1) : mant_p1_q;
        amt2_p1  = amt_p1_q + {{(AW-1){1'b0}}, need_p1};
        diff_p1  = $signed({1'b0, exp_p1_q} - {{(E+1-AW){1'b0}}, amt2_p1});

        out_mant_d = mant2_p1;
        out_exp_d  = diff_p1[E-1:0];
        out_zero_d = 1'b0;
        out_uf_d   = 1'b0;
        out_corr_d = fix_p1_q | need_p1;
        if (zero_p1_q) begin
            out_mant_d = '0;
            out_exp_d  = '0;
            out_zero_d = 1'b1;
            out_corr_d = 1'b0;
        end else if (diff_p1 < ONE_S) begin
            out_mant_d = '0;
            out_exp_d  = '0;
            out_uf_d   = 1'b1;
        end
    end

    // Output stage registers; they hold steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q   <= 1'b0;
            out_mant_q <= '0;
            out_exp_q  <= '0;
            out_zero_q <= 1'b0;
            out_uf_q   <= 1'b0;
            out_corr_q <= 1'b0;
        end else if (adv2) begin
            vld_p2_q   <= vld_p1_q;
            out_mant_q <= out_mant_d;
            out_exp_q  <= out_exp_d;
            out_zero_q <= out_zero_d;
            out_uf_q   <= out_uf_d;
            out_corr_q <= out_corr_d;
        end
    end

    // Count corrected beats as they leave; a clear takes priority over a count.
    always_ff @(posedge clk) begin
        if (rst || corr_clear) begin
            cnt_q <= '0;
        end else if (vld_p2_q && out_ready && out_corr_q) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign out_valid     = vld_p2_q;
    assign out_mant      = out_mant_q;
    assign out_exp       = out_exp_q;
    assign out_zero      = out_zero_q;
    assign out_underflow = out_uf_q;
    assign out_corrected = out_corr_q;
    assign corr_count    = cnt_q;

endmodule

// File: tb/tb_hub_norm_shifter.sv
// Testbench for hub_norm_shifter: directed cases, backpressure, reset in the
// middle of a stream, counter saturation/clear, and randomized traffic scored
// against a leading-one based reference model.
module tb_hub_norm_shifter;

    localparam int M  = 23;
    localparam int E  = 8;
    localparam int SW = $clog2(M + 2);
    localparam int CW = 16;
    localparam int W  = M + 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_mant;
    logic [SW-1:0] in_shift;
    logic [E-1:0]  in_exp;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_mant;
    logic [E-1:0]  out_exp;
    logic          out_zero;
    logic          out_underflow;
    logic          out_corrected;
    logic [CW-1:0] corr_count;
    logic          corr_clear;

    hub_norm_shifter #(.M(M), .E(E), .SHIFT_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mant      (in_mant),
        .in_shift     (in_shift),
        .in_exp       (in_exp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mant     (out_mant),
        .out_exp      (out_exp),
        .out_zero     (out_zero),
        .out_underflow(out_underflow),
        .out_corrected(out_corrected),
        .corr_count   (corr_count),
        .corr_clear   (corr_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] mant;
        logic [E-1:0] exp;
        logic         zero;
        logic         uf;
        logic         corr;
    } exp_t;

    int            n_checks = 0;
    int            n_err    = 0;
    exp_t          sb_q[$];
    logic [CW-1:0] mcnt;
    logic          stall_prev;
    logic [W-1:0]  h_mant;
    logic [E-1:0]  h_exp;
    logic [2:0]    h_flags;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // The true normalizing shift is the distance from the leading one to the MSB.
    function automatic exp_t ref_model(input logic [W-1:0] m, input logic [SW-1:0] sh,
                                       input logic [E-1:0] ex);
        exp_t r;
        int   lead;
        int   s;
        int   d;
        r = '0;
        if (m == '0) begin
            r.zero = 1'b1;
            return r;
        end
        lead = 0;
        for (int i = 0; i < W; i++) if (m[i]) lead = i;
        s = W - 1 - lead;
        r.corr = (int'(sh) != s);
        d = int'(ex) - s;
        if (d < 1) begin
            r.uf = 1'b1;
            return r;
        end
        r.mant = m << s;
        r.exp  = d[E-1:0];
        return r;
    endfunction

    // Random in-contract beat: LZA prediction within one bit of the truth.
    task automatic gen_beat(output logic [W-1:0] m, output logic [SW-1:0] sh,
                            output logic [E-1:0] ex);
        int p;
        int s;
        int dlt;
        logic [W-1:0] low;
        ex = ($urandom_range(0, 1) == 0) ? E'($urandom_range(0, 40)) : E'($urandom_range(0, 255));
        if ($urandom_range(0, 15) == 0) begin
            m  = '0;
            sh = SW'($urandom_range(0, 31));
            return;
        end
        p   = $urandom_range(0, W - 1);
        low = W'($urandom);
        m   = (W'(1) << p) | (low & ((W'(1) << p) - W'(1)));
        s   = W - 1 - p;
        dlt = $urandom_range(0, 2) - 1;
        if (s + dlt < 0) dlt = 0;
        sh  = SW'(s + dlt);
    endtask

    // One clock cycle: score the outputs, track accepted inputs, advance to next negedge.
    task automatic cycle();
        exp_t e;
        logic xfer;
        logic xcorr;
        #1;
        chk("corr_count", 32'(corr_count), 32'(mcnt));
        if (stall_prev) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_mant", 32'(out_mant), 32'(h_mant));
            chk("hold_exp", 32'(out_exp), 32'(h_exp));
            chk("hold_flags", 32'({out_zero, out_underflow, out_corrected}), 32'(h_flags));
        end
        xfer  = 1'b0;
        xcorr = 1'b0;
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("out_mant", 32'(out_mant), 32'(e.mant));
                chk("out_exp", 32'(out_exp), 32'(e.exp));
                chk("out_zero", 32'(out_zero), 32'(e.zero));
                chk("out_underflow", 32'(out_underflow), 32'(e.uf));
                chk("out_corrected", 32'(out_corrected), 32'(e.corr));
                xfer  = 1'b1;
                xcorr = e.corr;
            end
        end
        if (corr_clear) mcnt = '0;
        else if (xfer && xcorr && mcnt != {CW{1'b1}}) mcnt = mcnt + 1'b1;
        if (in_valid && in_ready) sb_q.push_back(ref_model(in_mant, in_shift, in_exp));
        stall_prev = out_valid && !out_ready;
        h_mant  = out_mant;
        h_exp   = out_exp;
        h_flags = {out_zero, out_underflow, out_corrected};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; corr_clear = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        mcnt = '0;
        stall_prev = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_corr_count", 32'(corr_count), 32'd0);
        chk("rst_out_mant", 32'(out_mant), 32'd0);
        chk("rst_out_exp", 32'(out_exp), 32'd0);
        chk("rst_flags", 32'({out_zero, out_underflow, out_corrected}), 32'd0);
    endtask

    // Single beat into an empty pipe; outputs checked against literal expectations.
    task automatic directed(input string tag, input logic [W-1:0] m, input logic [SW-1:0] sh,
                            input logic [E-1:0] ex, input logic [W-1:0] em,
                            input logic [E-1:0] ee, input logic ez, input logic eu,
                            input logic ec);
        in_valid = 1'b1; in_mant = m; in_shift = sh; in_exp = ex;
        out_ready = 1'b1; corr_clear = 1'b0;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_mant"}, 32'(out_mant), 32'(em));
        chk({tag, "_exp"}, 32'(out_exp), 32'(ee));
        chk({tag, "_zero"}, 32'(out_zero), 32'(ez));
        chk({tag, "_uf"}, 32'(out_underflow), 32'(eu));
        chk({tag, "_corr"}, 32'(out_corrected), 32'(ec));
        cycle();
    endtask

    initial begin
        logic [W-1:0]  bm[4];
        logic [SW-1:0] bs[4];
        logic [E-1:0]  be[4];
        int b;
        rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_shift = '0; in_exp = '0;
        out_ready = 1'b0; corr_clear = 1'b0;
        mcnt = '0; stall_prev = 1'b0; h_mant = '0; h_exp = '0; h_flags = '0;
        @(negedge clk);
        do_reset();

        directed("exact", 25'h0100000, 5'd4, 8'd100, 25'h1000000, 8'd96, 1'b0, 1'b0, 1'b0);
        chk("cnt_after_exact", 32'(corr_count), 32'd0);
        directed("under", 25'h0100000, 5'd3, 8'd100, 25'h1000000, 8'd96, 1'b0, 1'b0, 1'b1);
        chk("cnt_after_under", 32'(corr_count), 32'd1);
        directed("over", 25'h0100000, 5'd5, 8'd100, 25'h1000000, 8'd96, 1'b0, 1'b0, 1'b1);
        chk("cnt_after_over", 32'(corr_count), 32'd2);
        directed("zero", 25'h0000000, 5'd7, 8'd50, 25'h0, 8'd0, 1'b1, 1'b0, 1'b0);
        directed("uflow", 25'h0100000, 5'd4, 8'd4, 25'h0, 8'd0, 1'b0, 1'b1, 1'b0);
        directed("lsb_over", 25'h0000001, 5'd25, 8'd30, 25'h1000000, 8'd6, 1'b0, 1'b0, 1'b1);

        // Backpressure: consumer stalled for 3 cycles while 4 beats are offered.
        for (int i = 0; i < 4; i++) gen_beat(bm[i], bs[i], be[i]);
        b = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 3);
            in_valid  = (b < 4);
            if (b < 4) begin
                in_mant = bm[b]; in_shift = bs[b]; in_exp = be[b];
            end
            #1;
            if (c == 2) begin
                chk("bp_accepted", 32'(b), 32'd2);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
            end
            if (in_valid && in_ready) b++;
            cycle();
        end
        chk("bp_drained", 32'(sb_q.size()), 32'd0);
        in_valid = 1'b0;

        // Reset with beats in flight: nothing stale may come out afterwards.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            gen_beat(in_mant, in_shift, in_exp);
            cycle();
        end
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_corr_count", 32'(corr_count), 32'd0);
        rst = 1'b0;
        sb_q.delete(); mcnt = '0; stall_prev = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk("midrst_idle", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with random stalls and occasional clears.
        for (int c = 0; c < 3000; c++) begin
            out_ready  = ($urandom_range(0, 3) != 0);
            in_valid   = ($urandom_range(0, 4) != 0);
            corr_clear = ($urandom_range(0, 31) == 0);
            gen_beat(in_mant, in_shift, in_exp);
            cycle();
        end
        in_valid = 1'b0; corr_clear = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        chk("rand_drained", 32'(sb_q.size()), 32'd0);

        // Counter saturation and clear priority.
        do_reset();
        out_ready = 1'b1;
        in_mant = 25'h0100000; in_shift = 5'd3; in_exp = 8'd100;
        in_valid = 1'b1;
        for (int c = 0; c < 65535; c++) cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("cnt_full", 32'(corr_count), 32'hFFFF);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("cnt_saturated", 32'(corr_count), 32'hFFFF);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("clr_beat_valid", 32'(out_valid), 32'd1);
        corr_clear = 1'b1;
        cycle();
        corr_clear = 1'b0;
        cycle();
        chk("cnt_clear_prio", 32'(corr_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/hub_norm_shifter.md
Name: hub_norm_shifter

Overview:
- Post-LZA normalization stage of the HUB floating-point adder datapath.
- Consumes the raw effective-subtraction magnitude, the LZA shift prediction and the pre-normalization exponent.
- Left-shifts the mantissa so the leading one lands in the MSB and corrects the LZA's possible one-bit misprediction in either direction.
- Adjusts the exponent, handles zero and underflow, and is a 2-stage valid/ready pipeline feeding the HUB rounding/packing logic.

Parameters:
- M, 23, fraction width; the datapath mantissa is W = M+2 bits (same M as the LZA).
- E, 8, exponent width.
- SHIFT_WIDTH, $clog2(M+2), width of the LZA shift amount.
- CNT_WIDTH, 16, width of the saturating correction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage 1 can accept.
- in_mant  in  M+2  unnormalized magnitude.
- in_shift  in  SHIFT_WIDTH  LZA predicted left-shift.
- in_exp  in  E  exponent before normalization (unsigned, biased).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_mant  out  M+2  normalized mantissa; MSB=1 unless zero/underflow.
- out_exp  out  E  adjusted exponent.
- out_zero  out  1  result is exact zero.
- out_underflow  out  1  exponent fell below 1; result flushed to zero.
- out_corrected  out  1  LZA prediction was off by one and was corrected.
- corr_count  out  CNT_WIDTH  saturating count of corrected beats.
- corr_clear  in  1  synchronous clear of corr_count.

Behaviour:
- Reset (rst=1 at a clk edge) clears both stage valids, all out_* data, and corr_count to 0. in_ready=1 the cycle after reset. A reset mid-stream discards in-flight beats.
- Handshake: a transfer occurs when valid&ready at a rising edge.
  - Stage 2 advances when !s2_valid | out_ready.
  - Stage 1 advances when !s1_valid | stage-2-advance.
  - in_ready = stage-1-advance (combinational from out_ready; no skid buffer).
- Data must hold while out_valid & !out_ready. Beat order is preserved.
- Latency: 2 cycles from input acceptance to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Stage 1 (coarse shift):
  - zero = (in_mant==0).
  - lost = any 1 shifted out above bit W-1 by in_shift, i.e. the LZA overestimated.
  - If lost: s1_mant = in_mant << (in_shift-1), s1_amt = in_shift-1, s1_fix=1.
  - Else: s1_mant = in_mant << in_shift, s1_amt = in_shift, s1_fix=0.
  - in_shift >= W with nonzero mantissa is treated via the lost path.
- Stage 2 (fine correction):
  - If !zero and s1_mant[W-1]==0 (LZA underestimated): mant = s1_mant<<1, amt = s1_amt+1, fix=1.
  - Otherwise mant and amt pass through.
  - Prediction error beyond one bit is out of contract: output is unspecified, but must not hang the pipeline.
- Exponent: diff = {1'b0,in_exp} - amt, computed in E+1 bits signed.
  - zero: out_mant=0, out_exp=0, out_zero=1, underflow=0, corrected=0.
  - Else if diff < 1: out_underflow=1, out_mant=0, out_exp=0 (HUB flush-to-zero).
  - Else: out_exp = diff[E-1:0].
- out_corrected = s1_fix | stage-2 fix. The two cannot both be set for in-contract input.
- corr_count: increments by 1 on each output transfer with out_corrected=1, saturating at all-ones.
  - corr_clear has priority over increment. Clear and increment in the same cycle gives 0.

Test Plan:
- Exact prediction: in_mant=25'h0100000, in_shift=4, in_exp=100, out_ready=1 -> 2 cycles later out_mant=25'h1000000, out_exp=96, corrected=0, zero=0, underflow=0.
- Underestimate: in_mant=25'h0100000, in_shift=3, in_exp=100 -> out_mant=25'h1000000, out_exp=96, out_corrected=1, corr_count=1.
- Overestimate: in_mant=25'h0100000, in_shift=5, in_exp=100 -> out_mant=25'h1000000, out_exp=96, out_corrected=1.
- Zero and underflow:
  - in_mant=0, in_shift=7 -> out_zero=1, out_mant=0, out_exp=0.
  - in_mant=25'h0100000, in_shift=4, in_exp=4 -> out_underflow=1, out_mant=0, out_exp=0.
- Backpressure: stream 4 beats with out_ready=0 for 3 cycles -> in_ready drops after 2 beats are accepted, outputs stay stable, all 4 emerge in order once out_ready=1. Assert rst mid-stream -> out_valid=0 next cycle and no stale beat appears.
- Counter: 0xFFFF corrected beats then 1 more -> corr_count holds 0xFFFF. corr_clear together with a corrected beat -> 0.
